// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: collects ch0..ch3 samples after a start-of-frame and holds the frame until consumed.
// Optional framing-error counter is built only when TDM_DEMUX_ERR_CNT_EN is defined.
module tdm_demux_4ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_ch0,
  output logic [WIDTH-1:0] out_ch1,
  output logic [WIDTH-1:0] out_ch2,
  output logic [WIDTH-1:0] out_ch3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       slot_r;
  logic [1:0]       slot_s;
  logic [3:0]       wr_s;
  logic             err_s;
  logic             in_ready_s;
  logic             xfer_s;
  logic             hunt_s;
  logic             out_valid_r;
  logic             sync_err_r;
  logic [WIDTH-1:0] ch_r [4];

  // Next-state, slot and channel-write decode.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    wr_s    = 4'b0000;
    err_s   = 1'b0;
    if (state_r == FULL) begin
      in_ready_s = out_ready;
    end else begin
      in_ready_s = 1'b1;
    end
    xfer_s = in_valid & in_ready_s;
    // A consumed FULL frame hunts for sof on the same edge, giving zero-bubble frames.
    hunt_s = (state_r == IDLE) || ((state_r == FULL) && out_ready);

    case (state_r)
      IDLE, FULL: begin
        if (state_r == FULL && out_ready) begin
          state_s = IDLE;
          slot_s  = 2'd0;
        end else begin
          state_s = state_r;
        end
        if (hunt_s && xfer_s) begin
          if (in_sof) begin
            wr_s[0] = 1'b1;
            slot_s  = 2'd1;
            state_s = COLLECT;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          err_s = 1'b0;
        end
      end
      COLLECT: begin
        if (xfer_s) begin
          if (in_sof) begin
            wr_s[0] = 1'b1;
            slot_s  = 2'd1;
            err_s   = 1'b1;
          end else begin
            wr_s[slot_r] = 1'b1;
            if (slot_r == 2'd3) begin
              slot_s  = 2'd0;
              state_s = FULL;
            end else begin
              slot_s = slot_r + 2'd1;
            end
          end
        end else begin
          slot_s = slot_r;
        end
      end
      default: begin
        state_s = IDLE;
        slot_s  = 2'd0;
      end
    endcase
  end

  // State, status and channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      slot_r      <= 2'd0;
      out_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ch_r[i] <= '0;
      end
    end else begin
      state_r     <= state_s;
      slot_r      <= slot_s;
      out_valid_r <= (state_s == FULL);
      sync_err_r  <= err_s;
      for (int i = 0; i < 4; i++) begin
        if (wr_s[i]) begin
          ch_r[i] <= in_data;
        end
      end
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating framing-error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (err_s && (err_cnt_r != 8'd255)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign err_count = err_cnt_r;
`else
  assign err_count = 8'd0;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign sync_err  = sync_err_r;
  assign out_ch0   = ch_r[0];
  assign out_ch1   = ch_r[1];
  assign out_ch2   = ch_r[2];
  assign out_ch3   = ch_r[3];

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed scenarios plus random traffic against a frame-level reference model.
module tb_tdm_demux_4ch;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic [WIDTH-1:0] out_ch0, out_ch1, out_ch2, out_ch3;
  logic             out_valid;
  logic             out_ready;
  logic             sync_err;
  logic [7:0]       err_count;

  tdm_demux_4ch #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_ready (in_ready),
    .out_ch0  (out_ch0),
    .out_ch1  (out_ch1),
    .out_ch2  (out_ch2),
    .out_ch3  (out_ch3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sync_err (sync_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Reference model: a frame is a list of accepted samples; a held frame blocks input until consumed.
  logic [WIDTH-1:0] m_out [4];
  int               m_len;
  bit               m_held;
  bit               m_err;
  int               m_cnt;
  bit               m_known = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d,
                            input bit ordy, input bit rdy);
    if (r) begin
      m_len = 0; m_held = 1'b0; m_err = 1'b0; m_cnt = 0; m_known = 1'b1;
      for (int i = 0; i < 4; i++) m_out[i] = '0;
    end else begin
      m_err = 1'b0;
      if (m_held && ordy) m_held = 1'b0;
      if (v && rdy) begin
        if (s) begin
          if (m_len > 0) m_err = 1'b1;
          m_out[0] = d;
          m_len = 1;
        end else if (m_len == 0) begin
          m_err = 1'b1;
        end else begin
          m_out[m_len] = d;
          m_len++;
          if (m_len == 4) begin
            m_held = 1'b1;
            m_len = 0;
          end
        end
      end
`ifdef TDM_DEMUX_ERR_CNT_EN
      if (m_err && m_cnt < 255) m_cnt++;
`endif
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic step(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d, input bit ordy);
    bit rdy;
    rst = r; in_valid = v; in_sof = s; in_data = d; out_ready = ordy;
    #1;
    rdy = m_held ? ordy : 1'b1;
    if (m_known) check_val("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    model_edge(r, v, s, d, ordy, rdy);
    #1;
    if (sync_err === 1'b1) pulse_cnt++;
    check_val("out_valid", {31'd0, out_valid}, {31'd0, m_held});
    check_val("sync_err", {31'd0, sync_err}, {31'd0, m_err});
    check_val("out_ch0", {16'd0, out_ch0}, {16'd0, m_out[0]});
    check_val("out_ch1", {16'd0, out_ch1}, {16'd0, m_out[1]});
    check_val("out_ch2", {16'd0, out_ch2}, {16'd0, m_out[2]});
    check_val("out_ch3", {16'd0, out_ch3}, {16'd0, m_out[3]});
    check_val("err_count", {24'd0, err_count}, m_cnt);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d0, d1, d2, d3, input bit ordy);
    step(1'b0, 1'b1, 1'b1, d0, ordy);
    step(1'b0, 1'b1, 1'b0, d1, ordy);
    step(1'b0, 1'b1, 1'b0, d2, ordy);
    step(1'b0, 1'b1, 1'b0, d3, ordy);
  endtask

  initial begin
    int p0;
    int pos;
    bit rdy;
    bit s;
    bit v;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 16'h5A5A, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Basic frame, then consume.
    p0 = pulse_cnt;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_val("basic_no_sync_err", pulse_cnt - p0, 0);

    // Stray sample while hunting.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h00AA, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Back-pressure: held frame, next sof waits for out_ready.
    send_frame(16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h6666, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h7777, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h8888, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Aborted partial frame, with a gap.
    p0 = pulse_cnt;
    step(1'b0, 1'b1, 1'b1, 16'h000A, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h000B, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b1);
    send_frame(16'h000C, 16'h000D, 16'h000E, 16'h000F, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_val("abort_pulses", pulse_cnt - p0, 1);

    // Reset mid-frame, then a clean frame.
    step(1'b0, 1'b1, 1'b1, 16'h0009, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0019, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0029, 1'b1);
    send_frame(16'hA001, 16'hA002, 16'hA003, 16'hA004, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // 300 stray samples: counter saturates (when built), one pulse per sample.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    p0 = pulse_cnt;
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 16'(i), 1'b1);
    check_val("stray_pulses", pulse_cnt - p0, 300);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Random traffic: mostly well-framed, occasional framing errors and resets.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        pos = 0;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = (pos == 0) ^ ($urandom_range(0, 15) == 0);
        rdy = ($urandom_range(0, 9) < 7);
        if (v && (!m_held || rdy)) pos = s ? 1 : ((pos == 0) ? 0 : (pos + 1) % 4);
        step(1'b0, v, s, 16'($urandom), rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
